// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter sharing one synchronous FIFO write port among
//   NUM_REQ valid/ready producers. A producer keeps the port for up to
//   BURST_LEN beats, then the search for the next owner restarts just above it.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_req_valid   per-producer valid
//   i_req_data    producer k payload at [k*SIZE_DATA +: SIZE_DATA]
//   o_req_ready   per-producer accept (one-hot or zero)
//   i_fifo_full   FIFO full flag
//   o_fifo_wr_en  FIFO write enable
//   o_fifo_data   FIFO write data (payload, or {grant_id, payload} when tagged)
//   o_grant_id    current / last granted producer
//   o_busy        high while a producer owns the port
//
// Build option
//   FIFO_ARB_TAG_EN  when defined, o_fifo_data carries the producer index
//                    above the payload (SIZE_DATA+ID_W bits wide).

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 8,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic                         i_fifo_full,
  output logic                         o_fifo_wr_en,
`ifdef FIFO_ARB_TAG_EN
  output logic [SIZE_DATA+ID_W-1:0]    o_fifo_data,
`else
  output logic [SIZE_DATA-1:0]         o_fifo_data,
`endif
  output logic [ID_W-1:0]              o_grant_id,
  output logic                         o_busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] rr_ptr;
  logic [7:0]      beat_cnt;

  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic            gnt_valid;
  logic            xfer;
  logic            last_beat;
  logic [ID_W-1:0] next_ptr;
  logic [SIZE_DATA-1:0] gnt_payload;

  // Rotating priority search: first valid producer at or above rr_ptr.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_found && i_req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  assign gnt_valid   = i_req_valid[grant_id];
  assign gnt_payload = i_req_data[grant_id*SIZE_DATA +: SIZE_DATA];
  // Reset gates the transfer so an abandoned burst never writes a partial beat.
  assign xfer        = i_rst_n && (state == GRANT) && gnt_valid && !i_fifo_full;
  assign last_beat   = (beat_cnt == 8'(BURST_LEN - 1));
  assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  assign o_fifo_wr_en = xfer;
  assign o_req_ready  = xfer ? (NUM_REQ'(1) << grant_id) : '0;
`ifdef FIFO_ARB_TAG_EN
  assign o_fifo_data  = xfer ? {grant_id, gnt_payload} : '0;
`else
  assign o_fifo_data  = xfer ? gnt_payload : '0;
`endif
  assign o_grant_id   = grant_id;
  assign o_busy       = (state == GRANT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A full FIFO holds the grant and freezes the count; only the
          // owner dropping valid or the final beat releases the port.
          if (!gnt_valid) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (!i_fifo_full) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
